dcache_controller: RTL
======================

// Module: dcache_controller
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and the
//  128-bit block data memory. It is the initiator of the block memory protocol: it issues
//  mem_read/mem_write and waits out mem_busywait.
//  Word-only CPU accesses; hits complete with no stall; misses stall the CPU via cpu_busywait.
// PARAMETERS
//  NUM_SETS     8    number of cache lines (power of 2); index width IDX_W = log2(NUM_SETS)
//  ADDR_WIDTH   32   CPU byte-address width
//  WORD_WIDTH   32   CPU data width
//  BLOCK_WIDTH  128  line/memory block width (4 words); block offset = address[3:0]
// PORTS
//  clock          in   1    rising-edge clock
//  reset          in   1    asynchronous, active-high reset
//  cpu_read       in   1    load request, held until cpu_busywait low
//  cpu_write      in   1    store request, held until cpu_busywait low
//  cpu_address    in   32   byte address; [1:0] ignored, [3:2] word select, [3+IDX_W:4] index, rest tag
//  cpu_writedata  in   32   store data
//  cpu_readdata   out  32   load data, valid while cpu_read && !cpu_busywait
//  cpu_busywait   out  1    stall CPU
//  mem_read       out  1    block read request to data memory
//  mem_write      out  1    block write request to data memory
//  mem_address    out  28   block address (byte address [31:4])
//  mem_writedata  out  128  victim block for write-back
//  mem_readdata   in   128  fetched block, valid when mem_busywait falls during a read
//  mem_busywait   in   1    memory busy; memory takes 16 clock beats (one byte per beat) per block
// BEHAVIOUR
//  Reset (async): all valid/dirty bits 0, state IDLE; mem_read=mem_write=0, cpu_busywait=0,
//   mem_address=0, mem_writedata=0, cpu_readdata=0. Reset mid-miss aborts: request lines drop
//   immediately, line array is not updated.
//  Request = cpu_read XOR cpu_write. Both high or both low = no access, cpu_busywait=0.
//  Hit = valid[idx] && tag[idx]==cpu tag. Comb. in IDLE.
//  FSM IDLE/WRITEBACK/ALLOCATE/UPDATE:
//   IDLE: read hit -> cpu_readdata = selected word combinationally, cpu_busywait=0 (0 latency).
//     write hit -> word written at posedge, dirty[idx]=1, cpu_busywait=0.
//     miss -> cpu_busywait=1 combinationally; next state WRITEBACK if valid&&dirty else ALLOCATE.
//   WRITEBACK: mem_write=1, mem_address={victim tag,idx}, mem_writedata=victim line; held stable.
//     Exit to ALLOCATE on first posedge with mem_busywait==0 at least 1 cycle after entry.
//   ALLOCATE: mem_read=1, mem_address=cpu_address[31:4]; same exit rule -> UPDATE,
//     capture mem_readdata on that edge.
//   UPDATE (1 cycle): mem_read=mem_write=0; line<=captured block, tag written, valid=1, dirty=0;
//     -> IDLE, where the request now hits and completes (store then sets dirty).
//  cpu_busywait=1 in every non-IDLE state. mem_read/mem_write never both 1; each drops for >=1
//   cycle between WRITEBACK and ALLOCATE so the memory sees a fresh request edge.
//  Miss penalty: clean ~ 1+17+1 cycles; dirty ~ 2x memory time + 2.
//  CPU must hold address/data while stalled; changes during a miss are unsupported.
//  Index/tag arithmetic is pure bit slicing; no wrap concerns. Address 0xFFFF_FFF0 is a normal line.
// STRUCTURE
//  dcache_defs.vh: FSM state encodings, field widths (OFFSET_W=4, IDX_W, TAG_W), word-select macro.
//  Sub-module dcache_line_array: valid/dirty/tag/data storage, async read, sync write port with
//   word-write and full-line-fill modes, async clear on reset. FSM + muxing stay in dcache_controller.
// TESTING (bench pairs with the 16-beat block data memory model)
//  1 reset, read 0x0000_0040 -> clean miss: one mem_read of addr 0x4, no mem_write; data = mem[0x40..43].
//  2 repeat read 0x40 -> cpu_busywait never rises; data same cycle.
//  3 write 0xDEADBEEF @0x44 (hit) -> no mem traffic, dirty set; read 0x44 returns 0xDEADBEEF.
//  4 read 0x0000_00C0 (same index 4, new tag) -> mem_write addr 0x4 carrying 0xDEADBEEF in bits
//    [63:32], then mem_read addr 0xC; memory byte 0x44 = 0xEF afterwards.
//  5 cpu_read=cpu_write=1 -> cpu_busywait=0, no mem request, no state change.
//  6 assert reset in ALLOCATE -> mem_read drops same time, all lines invalid; next read re-misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared widths, FSM encoding and word helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int NUM_SETS    = 8;
    localparam int ADDR_WIDTH  = 32;
    localparam int WORD_WIDTH  = 32;
    localparam int BLOCK_WIDTH = 128;

    localparam int OFFSET_W   = 4;
    localparam int IDX_W      = $clog2(NUM_SETS);
    localparam int TAG_W      = ADDR_WIDTH - OFFSET_W - IDX_W;
    localparam int BLK_ADDR_W = ADDR_WIDTH - OFFSET_W;
    localparam int SEL_W      = 2;
    localparam int SEL_LSB    = 2;

    typedef logic [IDX_W-1:0]       idx_t;
    typedef logic [TAG_W-1:0]       tag_t;
    typedef logic [SEL_W-1:0]       sel_t;
    typedef logic [WORD_WIDTH-1:0]  word_t;
    typedef logic [BLOCK_WIDTH-1:0] block_t;
    typedef logic [BLK_ADDR_W-1:0]  blk_addr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE,
        S_UPDATE
    } state_e;

    function automatic word_t word_sel(input block_t b, input sel_t s);
        return b[int'(s)*WORD_WIDTH +: WORD_WIDTH];
    endfunction

    function automatic block_t word_merge(input block_t b, input sel_t s,
                                          input word_t w);
        block_t r;
        r = b;
        r[int'(s)*WORD_WIDTH +: WORD_WIDTH] = w;
        return r;
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage: async read, sync word-write or line-fill,
// valid and dirty bits cleared asynchronously on reset.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  idx_t   rd_idx,
    output logic   rd_valid,
    output logic   rd_dirty,
    output tag_t   rd_tag,
    output block_t rd_line,
    input  logic   wr_word_en,
    input  logic   wr_fill_en,
    input  idx_t   wr_idx,
    input  sel_t   wr_sel,
    input  word_t  wr_word,
    input  tag_t   wr_tag,
    input  block_t wr_line
);

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    tag_t                tag_q  [NUM_SETS];
    block_t              data_q [NUM_SETS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_fill_en) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= 1'b0;
        end else if (wr_word_en) begin
            dirty_q[wr_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clock) begin
        if (wr_fill_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line;
        end else if (wr_word_en) begin
            data_q[wr_idx] <= word_merge(data_q[wr_idx], wr_sel, wr_word);
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Hits complete combinationally; misses run the WRITEBACK/ALLOCATE/UPDATE FSM.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpu_read,
    input  logic                   cpu_write,
    input  logic [ADDR_WIDTH-1:0]  cpu_address,
    input  logic [WORD_WIDTH-1:0]  cpu_writedata,
    output logic [WORD_WIDTH-1:0]  cpu_readdata,
    output logic                   cpu_busywait,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [BLK_ADDR_W-1:0]  mem_address,
    output logic [BLOCK_WIDTH-1:0] mem_writedata,
    input  logic [BLOCK_WIDTH-1:0] mem_readdata,
    input  logic                   mem_busywait
);

    state_e    state_q;
    logic      mem_read_q;
    logic      mem_write_q;
    blk_addr_t mem_addr_q;
    block_t    mem_wdata_q;
    block_t    fill_q;

    idx_t      idx;
    tag_t      tag;
    sel_t      sel;
    blk_addr_t blk;
    logic      unused_addr_bits;

    logic      line_valid;
    logic      line_dirty;
    tag_t      line_tag;
    block_t    line_data;

    logic      req;
    logic      hit;
    logic      in_idle;
    logic      rd_hit;
    logic      wr_hit;
    logic      fill_en;

    assign idx = cpu_address[OFFSET_W +: IDX_W];
    assign tag = cpu_address[ADDR_WIDTH-1 -: TAG_W];
    assign sel = cpu_address[SEL_LSB +: SEL_W];
    assign blk = cpu_address[ADDR_WIDTH-1 -: BLK_ADDR_W];
    assign unused_addr_bits = ^cpu_address[SEL_LSB-1:0];

    assign req     = cpu_read ^ cpu_write;
    assign hit     = line_valid && (line_tag == tag);
    assign in_idle = (state_q == S_IDLE);
    assign rd_hit  = in_idle && cpu_read && !cpu_write && hit;
    assign wr_hit  = in_idle && cpu_write && !cpu_read && hit;
    assign fill_en = (state_q == S_UPDATE);

    dcache_line_array u_lines (
        .clock      (clock),
        .reset      (reset),
        .rd_idx     (idx),
        .rd_valid   (line_valid),
        .rd_dirty   (line_dirty),
        .rd_tag     (line_tag),
        .rd_line    (line_data),
        .wr_word_en (wr_hit),
        .wr_fill_en (fill_en),
        .wr_idx     (idx),
        .wr_sel     (sel),
        .wr_word    (cpu_writedata),
        .wr_tag     (tag),
        .wr_line    (fill_q)
    );

    // Reset forces the CPU-facing outputs quiet even if a request is held.
    assign cpu_busywait = !reset && (!in_idle || (req && !hit));
    assign cpu_readdata = (!reset && rd_hit) ? word_sel(line_data, sel) : '0;

    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_addr_q;
    assign mem_writedata = mem_wdata_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fill_q      <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req && !hit) begin
                        if (line_valid && line_dirty) begin
                            state_q     <= S_WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {line_tag, idx};
                            mem_wdata_q <= line_data;
                        end else begin
                            state_q    <= S_ALLOCATE;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= blk;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (!mem_busywait) begin
                        state_q     <= S_ALLOCATE;
                        mem_write_q <= 1'b0;
                    end
                end
                S_ALLOCATE: begin
                    // After a write-back the read is raised one cycle late
                    // so memory sees a fresh request edge.
                    if (!mem_read_q) begin
                        mem_read_q <= 1'b1;
                        mem_addr_q <= blk;
                    end else if (!mem_busywait) begin
                        state_q    <= S_UPDATE;
                        mem_read_q <= 1'b0;
                        fill_q     <= mem_readdata;
                    end
                end
                S_UPDATE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
